// File: rtl/mcu_spi_pkg.sv
// mcu_spi_pkg: shared types and defaults for the MCU SPI target.
// State encoding and parameter defaults live here.
package mcu_spi_pkg;

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_state_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int TIMEOUT_DEF     = 65535;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with rise/fall detect.
// Edges are taken from the last two synchronised samples.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the async input through the chain, keep one older sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/mcu_spi_target.sv
// mcu_spi_target: SPI mode 0 target, MSB first, byte strobes to clk.
// Optional stall abort enabled by defining MCU_SPI_TIMEOUT_EN.
module mcu_spi_target
  import mcu_spi_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_ss_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       data_in_strobe,
  output logic       data_in_start,
  output logic [7:0] data_in,
  input  logic [7:0] data_out,
  output logic       spi_timeout
);

  spi_state_e state, state_n;

  logic                   sclk_rise, sclk_fall;
  logic                   ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   mosi_s;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx, tx;
  logic                   first;
  logic                   to_fire;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (spi_sclk),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  // ss_n chain resets low so a select held low through reset
  // produces no fall; a fresh fall is needed to go active.
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (spi_ss_n),
    .rise     (ss_rise),
    .fall     (ss_fall)
  );

  // MOSI synchroniser, same depth so it lines up with sclk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mosi_q <= '0;
    end else begin
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign mosi_s = mosi_q[SYNC_STAGES-1];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state from select edges
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (ss_fall) state_n = ACTIVE;
      ACTIVE:  if (ss_rise) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Shift registers, bit counter and byte strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt        <= 3'd0;
      rx             <= 8'h00;
      tx             <= 8'h00;
      first          <= 1'b1;
      data_in        <= 8'h00;
      data_in_strobe <= 1'b0;
      data_in_start  <= 1'b0;
    end else begin
      data_in_strobe <= 1'b0;
      data_in_start  <= 1'b0;
      if (ss_rise) begin
        bit_cnt <= 3'd0;
      end else if (ss_fall && state == IDLE) begin
        bit_cnt <= 3'd0;
        first   <= 1'b1;
        tx      <= 8'h00;
      end else if (state == ACTIVE) begin
        if (sclk_rise) begin
          rx      <= {rx[6:0], mosi_s};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            data_in        <= {rx[6:0], mosi_s};
            data_in_strobe <= 1'b1;
            data_in_start  <= first;
            first          <= 1'b0;
          end
        end else if (sclk_fall) begin
          if (bit_cnt != 3'd0) begin
            tx <= {tx[6:0], 1'b0};
          end else if (!first) begin
            tx <= data_out;
          end
        end else if (to_fire) begin
          bit_cnt <= 3'd0;
          rx      <= 8'h00;
        end
      end
    end
  end

  assign spi_miso = (state == ACTIVE) & tx[7];

`ifdef MCU_SPI_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_idle;

  assign to_idle = (state != ACTIVE) || (bit_cnt == 3'd0)
                || sclk_rise || sclk_fall || ss_rise;
  assign to_fire = !to_idle && (to_cnt == TO_LAST);

  // Stall counter for partial bytes, one-clk abort pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt      <= '0;
      spi_timeout <= 1'b0;
    end else begin
      spi_timeout <= to_fire;
      if (to_idle || to_fire) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_fire        = 1'b0;
  assign spi_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_mcu_spi_target.sv
// tb_mcu_spi_target: vector table plus corner sequences,
// strobes checked against a queue of expected bytes.
module tb_mcu_spi_target;

  localparam int HALF = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       start;
  } exp_t;

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] resp;
    logic [7:0] miso;
    logic       start;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       spi_ss_n;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       data_in_strobe;
  logic       data_in_start;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       spi_timeout;

  int   checks = 0;
  int   errors = 0;
  int   to_seen = 0;
  logic [7:0] resp_next = 8'h00;
  exp_t exp_q[$];
  vec_t vt[3];

  always #5 clk = ~clk;

  mcu_spi_target #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .spi_ss_n       (spi_ss_n),
    .spi_sclk       (spi_sclk),
    .spi_mosi       (spi_mosi),
    .spi_miso       (spi_miso),
    .data_in_strobe (data_in_strobe),
    .data_in_start  (data_in_start),
    .data_in        (data_in),
    .data_out       (data_out),
    .spi_timeout    (spi_timeout)
  );

  task automatic check(input string name,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare strobes against the scoreboard; act as downstream
  task automatic poll();
    exp_t e;
    if (data_in_strobe) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {7'd0, data_in_strobe}, 8'h00);
      end else begin
        e = exp_q.pop_front();
        check("data_in", data_in, e.data);
        check("data_in_start", {7'd0, data_in_start},
              {7'd0, e.start});
      end
      data_out = resp_next;
    end
    if (spi_timeout) to_seen++;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(negedge clk);
      poll();
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n,
                          output logic [7:0] so);
    so = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      wait_clk(HALF);
      so = {so[6:0], spi_miso};
      spi_sclk = 1'b1;
      wait_clk(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic s);
    exp_t e;
    e.data  = d;
    e.start = s;
    exp_q.push_back(e);
  endtask

  task automatic ss_low();
    spi_ss_n = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic ss_high();
    spi_ss_n = 1'b1;
    wait_clk(HALF * 2);
  endtask

  initial begin
    logic [7:0] so;
    logic [7:0] hold;

    data_out = 8'h00;
    reset_n  = 1'b0;
    spi_ss_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;

    vt[0] = '{mosi: 8'h00, resp: 8'h5C, miso: 8'h00, start: 1'b1};
    vt[1] = '{mosi: 8'hAA, resp: 8'h42, miso: 8'h5C, start: 1'b0};
    vt[2] = '{mosi: 8'hBB, resp: 8'h99, miso: 8'h42, start: 1'b0};

    repeat (3) @(negedge clk);
    check("rst_miso", {7'd0, spi_miso}, 8'h00);
    check("rst_strobe", {7'd0, data_in_strobe}, 8'h00);
    check("rst_start", {7'd0, data_in_start}, 8'h00);
    check("rst_data_in", data_in, 8'h00);
    check("rst_timeout", {7'd0, spi_timeout}, 8'h00);
    reset_n = 1'b1;
    wait_clk(HALF);

    // Three-byte transaction with downstream responses
    ss_low();
    foreach (vt[i]) begin
      resp_next = vt[i].resp;
      push_exp(vt[i].mosi, vt[i].start);
      spi_bits(vt[i].mosi, 8, so);
      check("miso_byte", so, vt[i].miso);
    end
    wait_clk(HALF);
    ss_high();
    check("sb_drain_a", 8'(exp_q.size()), 8'h00);

    // Aborted partial byte, then a fresh first byte
    ss_low();
    spi_bits(8'hF0, 5, so);
    ss_high();
    ss_low();
    push_exp(8'h04, 1'b1);
    spi_bits(8'h04, 8, so);
    wait_clk(HALF);
    ss_high();
    check("sb_drain_b", 8'(exp_q.size()), 8'h00);

    // Select rises together with the 8th sclk rise
    hold = data_in;
    ss_low();
    spi_bits(8'h7E, 7, so);
    spi_mosi = 1'b0;
    wait_clk(HALF);
    spi_sclk = 1'b1;
    spi_ss_n = 1'b1;
    wait_clk(HALF * 3);
    spi_sclk = 1'b0;
    wait_clk(HALF);
    check("ss_race_data_in", data_in, hold);
    check("ss_race_data_in_abs", data_in, 8'h04);

    // Asynchronous reset in the middle of a byte
    ss_low();
    spi_bits(8'hFF, 4, so);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_data_in", data_in, 8'h00);
    check("arst_strobe", {7'd0, data_in_strobe}, 8'h00);
    check("arst_start", {7'd0, data_in_start}, 8'h00);
    check("arst_miso", {7'd0, spi_miso}, 8'h00);
    check("arst_timeout", {7'd0, spi_timeout}, 8'h00);
    wait_clk(3);
    reset_n = 1'b1;
    ss_high();
    ss_low();
    push_exp(8'h01, 1'b1);
    spi_bits(8'h01, 8, so);
    wait_clk(HALF);
    ss_high();
    check("sb_drain_c", 8'(exp_q.size()), 8'h00);

    // Stall after three bits of a second byte
    to_seen = 0;
    ss_low();
    resp_next = 8'h00;
    push_exp(8'h11, 1'b1);
    spi_bits(8'h11, 8, so);
    spi_bits(8'hA5, 3, so);
    wait_clk(130);
`ifdef MCU_SPI_TIMEOUT_EN
    check("timeout_pulses", 8'(to_seen), 8'h01);
    push_exp(8'h3C, 1'b0);
    spi_bits(8'h3C, 8, so);
`else
    check("timeout_pulses", 8'(to_seen), 8'h00);
    push_exp(8'hA5, 1'b0);
    spi_bits(8'h05 << 3, 5, so);
`endif
    wait_clk(HALF);
    ss_high();
    check("sb_drain_d", 8'(exp_q.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mcu_spi_target.md
MCU_SPI_TARGET -- requirements
Module: mcu_spi_target

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flip-flop depth of the input synchronisers for spi_ss_n, spi_sclk and spi_mosi.
REQ-002 Parameter TIMEOUT_CYCLES, default 65535: stall limit in clk cycles, used only under MCU_SPI_TIMEOUT_EN.
REQ-003 clk  input  1  system clock; one clock domain for the whole block.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 spi_ss_n  input  1  MCU chip select, active-low, asynchronous to clk.
REQ-006 spi_sclk  input  1  MCU SPI clock; SPI mode 0 (CPOL=0, CPHA=0), MSB first.
REQ-007 spi_mosi  input  1  MCU to FPGA serial data.
REQ-008 spi_miso  output  1  FPGA to MCU serial data.
REQ-009 data_in_strobe  output  1  one-clk pulse per complete received byte.
REQ-010 data_in_start  output  1  high only in the strobe cycle of the first byte after spi_ss_n falls.
REQ-011 data_in  output  8  last received byte; held stable until the next strobe.
REQ-012 data_out  input  8  response byte from the downstream command decoder; valid from 1 clk after the strobe.
REQ-013 spi_timeout  output  1  one-clk pulse when a stalled partial byte is aborted.

Function
REQ-014 SHALL synchronise all SPI inputs through SYNC_STAGES flops and detect SCK rising/falling edges from the last two synchronised samples.
REQ-015 SHALL implement states IDLE (ss high) and ACTIVE (ss low); ss falling: IDLE->ACTIVE, bit_cnt=0, first=1, tx=0x00; ss rising: ->IDLE.
REQ-016 On each SCK rising edge in ACTIVE: shift the MOSI sample into rx LSB; bit_cnt increments modulo 8.
REQ-017 On the rising edge that wraps bit_cnt 7->0: next clk data_in=rx byte, data_in_strobe=1, data_in_start=first; then first=0.
REQ-018 On SCK falling edge with bit_cnt!=0: tx shifts left by 1; with bit_cnt==0 and a byte already received: tx loads data_out.
REQ-019 spi_miso SHALL be tx[7] in ACTIVE and 0 in IDLE; the response to byte n is shifted out during byte n+1.
REQ-020 ss rise takes priority over a same-cycle SCK edge: partial or completing byte discarded, no strobe.
REQ-021 SCK edges while in IDLE SHALL be ignored.
REQ-022 Supported SCK half-period SHALL be >= SYNC_STAGES+3 clk cycles; faster SCK is out of scope.

Reset
REQ-023 While reset_n is low: state=IDLE, bit_cnt=0, rx=tx=0x00, data_in=0x00, data_in_strobe=0, data_in_start=0, spi_miso=0, spi_timeout=0, timeout counter=0.
REQ-024 Reset asserted mid-byte SHALL abort the transfer; after release the block waits for a fresh ss fall before accepting bits.

Configuration
REQ-025 Macro MCU_SPI_TIMEOUT_EN defined: in ACTIVE with bit_cnt!=0, a counter increments every clk and clears on any SCK edge. At TIMEOUT_CYCLES: bit_cnt=0, rx discarded, spi_timeout pulses for 1 clk, no strobe.
REQ-026 Macro not defined: no counter is built; spi_timeout is tied 0.

Structure
REQ-027 Package mcu_spi_pkg SHALL hold the state enum (IDLE, ACTIVE) and the defaults SYNC_STAGES_DEF=2 and TIMEOUT_DEF=65535.
REQ-028 SHALL use one sub-module, spi_sync_edge (synchroniser plus rise/fall detect), instantiated for spi_sclk and spi_ss_n.

Verification
REQ-029 ss low; send 0x00, 0xAA, 0xBB, where the downstream model returns 0x5C and 0x42 -> three strobes, start only on the first, data_in 0x00/0xAA/0xBB; MISO bytes 0x00/0x5C/0x42.
REQ-030 ss rises after 5 bits of 0xF0 -> no strobe; the next transaction's first byte 0x04 strobes with start=1.
REQ-031 ss rise in the same clk as the 8th SCK rising edge -> no strobe; data_in keeps its previous value.
REQ-032 reset_n pulsed low mid-byte -> all outputs at reset values immediately (async); a subsequent full byte 0x01 is received correctly.
REQ-033 With MCU_SPI_TIMEOUT_EN and TIMEOUT_CYCLES=100: 3 bits then a 100-clk stall -> spi_timeout pulse, bit_cnt=0; the next 8 bits 0x3C strobe data_in=0x3C with start=0.
REQ-034 Without the macro, same stimulus as REQ-033 -> no timeout; the remaining 5 bits complete one byte formed from 3+5 bits.
